retospect_bs_loader: RTL and testbench

- Transmit end of the neurochip configuration shift chain.
- Accepts configuration bytes over a valid/ready stream and serialises them LSB-first onto the chain's bs_in, gating each shift with config_en.
- Streams the bits displaced out of bs_out back as readback bytes, then issues a one-cycle reset_nn so neuron potentials and decay counters restart cleanly.
- Sits between the host/SPI front end and the clockbox + neuron array chain input.

---
 rtl/retospect_bs_loader.sv | 178 +++++++++++++++++
 tb/tb_retospect_bs_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/retospect_bs_loader.sv
// retospect_bs_loader
// Transmit end of the neurochip configuration shift chain. Takes configuration
// bytes from a valid/ready stream, shifts exactly CHAIN_LEN bits LSB-first into
// the chain (bs_in, gated by config_en), reassembles the bits displaced out of
// bs_out into readback bytes, then fires a one-cycle reset_nn and a done pulse.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a load (honoured only when idle)
//   in_data/in_valid/in_ready   configuration byte stream, bit 0 shifted first
//   config_en, bs_in    registered chain shift enable and serial data
//   bs_out              serial bit leaving the far end of the chain
//   reset_nn            registered one-cycle neuron/clock restart pulse
//   rb_data/rb_valid    readback byte strobe, first displaced bit in bit 0
//   busy, done          load in progress / one-cycle completion pulse
//   bit_count           bits shifted so far in the current load
module retospect_bs_loader #(
  parameter int CHAIN_LEN = 523,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             config_en,
  output logic             bs_in,
  input  logic             bs_out,
  output logic             reset_nn,
  output logic [7:0]       rb_data,
  output logic             rb_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] NBYTES_C = CNT_W'((CHAIN_LEN + 7) / 8);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NNPULSE, S_FINISH} state_t;

  state_t           state_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic [7:0]       sh_q;
  logic [3:0]       sh_cnt_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [7:0]       rb_sr_q;
  logic [2:0]       rb_cnt_q;
  logic             config_en_q;
  logic             bs_in_q;
  logic             reset_nn_q;
  logic [7:0]       rb_data_q;
  logic             rb_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             use_hold;
  logic [7:0]       buf_d;
  logic [3:0]       buf_cnt_d;
  logic             emit_d;
  logic             take;
  logic             last_smp;
  logic [7:0]       rb_byte_d;

  // An empty shift buffer draws straight from the hold register in the same
  // cycle, so a byte arriving every 8 cycles keeps config_en continuously high.
  always_comb begin
    in_ready  = (state_q == S_LOAD) && !hold_full_q && (acc_cnt_q < NBYTES_C);
    take      = in_valid && in_ready;
    use_hold  = (sh_cnt_q == 4'd0) && hold_full_q;
    buf_d     = use_hold ? hold_q : sh_q;
    buf_cnt_d = use_hold ? 4'd8 : sh_cnt_q;
    // Pad bits of the last byte are never shifted: the bit_count bound stops them.
    emit_d    = (state_q == S_LOAD) && (buf_cnt_d != 4'd0) && (bit_cnt_q < LEN_C);
    // The sample taken in the cycle of the final registered config_en.
    last_smp  = config_en_q && (rx_cnt_q == LAST_C);
    rb_byte_d = rb_sr_q | (8'(bs_out) << rb_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      sh_cnt_q    <= '0;
      acc_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      rx_cnt_q    <= '0;
      rb_sr_q     <= '0;
      rb_cnt_q    <= '0;
      config_en_q <= 1'b0;
      bs_in_q     <= 1'b0;
      reset_nn_q  <= 1'b0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rb_valid_q  <= 1'b0;
      reset_nn_q  <= 1'b0;
      done_q      <= 1'b0;
      config_en_q <= emit_d;

      if (emit_d) begin
        bs_in_q   <= buf_d[0];
        sh_q      <= buf_d >> 1;
        sh_cnt_q  <= buf_cnt_d - 4'd1;
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (use_hold) hold_full_q <= 1'b0;
      end

      if (take) begin
        hold_q      <= in_data;
        hold_full_q <= 1'b1;
        acc_cnt_q   <= acc_cnt_q + 1'b1;
      end

      // Readback: bit i lands at position i of its byte; the final partial
      // byte goes out with zeros above its last captured bit.
      if (config_en_q) begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
        if ((rb_cnt_q == 3'd7) || last_smp) begin
          rb_data_q  <= rb_byte_d;
          rb_valid_q <= 1'b1;
          rb_sr_q    <= '0;
          rb_cnt_q   <= '0;
        end else begin
          rb_sr_q  <= rb_byte_d;
          rb_cnt_q <= rb_cnt_q + 3'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            bit_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            rx_cnt_q    <= '0;
            hold_full_q <= 1'b0;
            sh_cnt_q    <= '0;
            rb_sr_q     <= '0;
            rb_cnt_q    <= '0;
          end
        end
        S_LOAD: begin
          if (last_smp) begin
            state_q    <= S_NNPULSE;
            reset_nn_q <= 1'b1;
          end
        end
        S_NNPULSE: begin
          state_q <= S_FINISH;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign config_en = config_en_q;
  assign bs_in     = bs_in_q;
  assign reset_nn  = reset_nn_q;
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Bench for retospect_bs_loader: a 12-bit chain instance (index 0) and a
// 523-bit chain instance (index 1), each attached to a behavioural chain model.
module tb_retospect_bs_loader;
  localparam int CW = 523;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s[2], start_s[2], in_valid_s[2], in_ready_s[2], ce_s[2], bs_in_s[2];
  logic bs_out_s[2], nn_s[2], rbv_s[2], busy_s[2], done_s[2], pl_req[2];
  logic [7:0] in_data_s[2], rbd_s[2];
  logic [9:0] bc_s[2];
  logic [CW-1:0] chain[2], pl_val[2];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] init;
    logic [7:0]  b0, b1;
    int          gap;
    logic [11:0] fin;
    logic [7:0]  rb0, rb1;
    int          runs;
    bit          extra;
  } vec_t;

  retospect_bs_loader #(.CHAIN_LEN(12), .CNT_W(10)) u_dut12 (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .in_data(in_data_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .config_en(ce_s[0]),
    .bs_in(bs_in_s[0]), .bs_out(bs_out_s[0]), .reset_nn(nn_s[0]), .rb_data(rbd_s[0]),
    .rb_valid(rbv_s[0]), .busy(busy_s[0]), .done(done_s[0]), .bit_count(bc_s[0]));

  retospect_bs_loader #(.CHAIN_LEN(523), .CNT_W(10)) u_dut523 (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .in_data(in_data_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .config_en(ce_s[1]),
    .bs_in(bs_in_s[1]), .bs_out(bs_out_s[1]), .reset_nn(nn_s[1]), .rb_data(rbd_s[1]),
    .rb_valid(rbv_s[1]), .busy(busy_s[1]), .done(done_s[1]), .bit_count(bc_s[1]));

  function automatic int lenof(input int g);
    return (g == 0) ? 12 : 523;
  endfunction

  // Chain model: shifts toward bit 0 on config_en, new bit enters at the top.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (pl_req[g]) chain[g] <= pl_val[g];
      else if (ce_s[g]) chain[g] <= (chain[g] >> 1) | (CW'(bs_in_s[g]) << (lenof(g) - 1));
    end
  end
  assign bs_out_s[0] = chain[0][0];
  assign bs_out_s[1] = chain[1][0];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_load(input int g, input logic [CW-1:0] init, input bit preload,
                          input logic [7:0] bytes[$], input int gaps[$], input int exp_runs,
                          input bit extra, output logic [CW-1:0] fin_chain,
                          output logic [7:0] rb[$]);
    int L, nb, bad;
    logic sb[$];
    logic obits[$];
    logic [7:0] exp_rb[$];
    logic [7:0] v;
    logic [CW-1:0] exp_fin;
    int ce_n, runs, nn_n, done_n, nn_c, done_c, last_ce, done_bc, prev_bc;
    bit prev, mono_ok, excl_ok, ready_ok, done_busy;
    L = lenof(g);
    nb = (L + 7) / 8;
    // Expected stream: first L bits of the byte stream; readback: the old chain.
    exp_fin = '0;
    for (int i = 0; i < L; i++) begin
      sb.push_back(bytes[i/8][i%8]);
      exp_fin[i] = bytes[i/8][i%8];
    end
    for (int k = 0; k < nb; k++) begin
      v = 8'h00;
      for (int j = 0; j < 8; j++) if (8*k + j < L) v[j] = init[8*k + j];
      exp_rb.push_back(v);
    end
    rb = {};
    ce_n = 0; runs = 0; nn_n = 0; done_n = 0; nn_c = -1; done_c = -1; last_ce = -1;
    done_bc = -1; prev_bc = 0; prev = 1'b0; mono_ok = 1'b1; excl_ok = 1'b1;
    ready_ok = 1'b1; done_busy = 1'b1;
    @(negedge clk);
    if (preload) begin pl_val[g] = init; pl_req[g] = 1'b1; end
    start_s[g] = 1'b1;
    @(negedge clk);
    pl_req[g] = 1'b0;
    start_s[g] = 1'b0;
    fork
      begin
        for (int i = 0; i < bytes.size(); i++) begin
          int n;
          if (gaps[i] > 0) begin
            @(negedge clk) in_valid_s[g] = 1'b0;
            repeat (gaps[i] - 1) @(negedge clk);
          end
          @(negedge clk);
          in_data_s[g] = bytes[i];
          in_valid_s[g] = 1'b1;
          n = 0;
          while (!in_ready_s[g] && n < 200) begin @(negedge clk); n++; end
          if (n >= 200) chk("byte_accept_timeout", i, -1);
        end
        @(negedge clk) in_valid_s[g] = 1'b0;
      end
      begin
        bit fin, pend;
        fin = 1'b0; pend = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
          @(negedge clk);
          if (pend) begin start_s[g] = 1'b0; pend = 1'b0; end
          if (ce_s[g]) begin
            obits.push_back(bs_in_s[g]);
            ce_n++;
            if (!prev) runs++;
            last_ce = c;
            if (extra && ce_n == 3) begin start_s[g] = 1'b1; pend = 1'b1; end
          end
          prev = ce_s[g];
          if (rbv_s[g]) rb.push_back(rbd_s[g]);
          if (nn_s[g]) begin
            nn_n++; nn_c = c;
            if (ce_s[g]) excl_ok = 1'b0;
            if (extra) begin start_s[g] = 1'b1; pend = 1'b1; end
          end
          if (int'(bc_s[g]) < prev_bc) mono_ok = 1'b0;
          prev_bc = int'(bc_s[g]);
          if (in_ready_s[g] && !busy_s[g]) ready_ok = 1'b0;
          if (done_s[g]) begin
            done_n++; done_c = c; done_bc = int'(bc_s[g]); done_busy = busy_s[g]; fin = 1'b1;
          end
        end
        if (!fin) chk("done_timeout", 0, 1);
      end
    join
    bad = 0;
    if (obits.size() != L) bad = 1000;
    else for (int i = 0; i < L; i++) if (obits[i] !== sb[i]) bad++;
    chk("bs_in_seq_errors", bad, 0);
    chk("config_en_cycles", ce_n, L);
    if (exp_runs >= 0) chk("config_en_runs", runs, exp_runs);
    chk("rb_count", rb.size(), nb);
    bad = 0;
    for (int k = 0; k < nb && k < rb.size(); k++) if (rb[k] !== exp_rb[k]) bad++;
    chk("rb_byte_errors", bad, 0);
    chk("final_chain_ok", (chain[g] === exp_fin) ? 1 : 0, 1);
    chk("reset_nn_pulses", nn_n, 1);
    chk("nn_after_last_shift", nn_c, last_ce + 1);
    chk("done_pulses", done_n, 1);
    chk("done_after_nn", done_c, nn_c + 1);
    chk("bit_count_at_done", done_bc, L);
    chk("busy_at_done", done_busy, 0);
    chk("bit_count_monotonic", mono_ok, 1);
    chk("ce_nn_exclusive", excl_ok, 1);
    chk("in_ready_outside_load", ready_ok, 1);
    fin_chain = chain[g];
    if (extra) begin
      repeat (3) @(negedge clk);
      chk("no_restart_busy", busy_s[g], 0);
      chk("bit_count_held", bc_s[g], L);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[5];
    logic [7:0] bq[$], rbq[$];
    int gq[$];
    logic [CW-1:0] fin, init, ret;
    int n, bad;

    for (int g = 0; g < 2; g++) begin
      rst_s[g] = 1'b1; start_s[g] = 1'b0; in_valid_s[g] = 1'b0; in_data_s[g] = 8'h00;
      pl_req[g] = 1'b0; pl_val[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk($sformatf("reset_outputs_%0d", g),
          {in_ready_s[g], ce_s[g], bs_in_s[g], nn_s[g], rbd_s[g], rbv_s[g],
           busy_s[g], done_s[g], bc_s[g]}, 0);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;

    // in_valid without start: never accepted, chain never shifted.
    @(negedge clk);
    in_valid_s[0] = 1'b1; in_data_s[0] = 8'hEE;
    n = 0;
    repeat (10) begin @(negedge clk); if (in_ready_s[0] || ce_s[0]) n++; end
    in_valid_s[0] = 1'b0;
    chk("idle_ready_or_shift", n, 0);

    tv[0] = '{12'hABC, 8'h5A, 8'h03, 0,  12'h35A, 8'hBC, 8'h0A, 1, 1'b0};
    tv[1] = '{12'hABC, 8'h5A, 8'h03, 20, 12'h35A, 8'hBC, 8'h0A, 2, 1'b0};
    tv[2] = '{12'h123, 8'hFF, 8'h0F, 0,  12'hFFF, 8'h23, 8'h01, 1, 1'b0};
    tv[3] = '{12'hFFF, 8'h00, 8'hF0, 5,  12'h000, 8'hFF, 8'h0F, 1, 1'b1};
    tv[4] = '{12'h000, 8'hA5, 8'h96, 20, 12'h6A5, 8'h00, 8'h00, 2, 1'b1};
    for (int i = 0; i < 5; i++) begin
      bq = {tv[i].b0, tv[i].b1};
      gq = {0, tv[i].gap};
      run_load(0, CW'(tv[i].init), 1'b1, bq, gq, tv[i].runs, tv[i].extra, fin, rbq);
      chk($sformatf("tv%0d_final", i), fin[11:0], tv[i].fin);
      chk($sformatf("tv%0d_rb_size", i), rbq.size(), 2);
      if (rbq.size() >= 2) begin
        chk($sformatf("tv%0d_rb0", i), rbq[0], tv[i].rb0);
        chk($sformatf("tv%0d_rb1", i), rbq[1], tv[i].rb1);
      end
    end

    // Reset after 5 shifted bits: outputs clear, chain keeps those 5 bits.
    @(negedge clk);
    pl_val[0] = CW'(12'hABC); pl_req[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    pl_req[0] = 1'b0; start_s[0] = 1'b0;
    @(negedge clk);
    in_data_s[0] = 8'h5A; in_valid_s[0] = 1'b1;
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin @(negedge clk); if (ce_s[0]) n++; end
    chk("bits_before_reset", n, 5);
    rst_s[0] = 1'b1;
    @(negedge clk);
    chk("midload_reset_outputs",
        {in_ready_s[0], ce_s[0], bs_in_s[0], nn_s[0], rbd_s[0], rbv_s[0],
         busy_s[0], done_s[0], bc_s[0]}, 0);
    rst_s[0] = 1'b0;
    ret = (CW'(12'hABC) >> 5) | (CW'(8'h5A & 8'h1F) << 7);
    chk("chain_retained_ok", (chain[0] === ret) ? 1 : 0, 1);
    bad = 0;
    repeat (20) begin @(negedge clk); if (ce_s[0] || rbv_s[0] || done_s[0] || busy_s[0]) bad++; end
    chk("quiet_after_reset", bad, 0);
    bq = {8'h5A, 8'h03}; gq = {0, 0};
    run_load(0, ret, 1'b0, bq, gq, 1, 1'b0, fin, rbq);

    // Randomized 12-bit loads.
    for (int r = 0; r < 6; r++) begin
      init = CW'($urandom_range(0, 4095));
      bq = {8'($urandom), 8'($urandom)};
      gq = {0, int'($urandom_range(0, 24))};
      run_load(0, init, 1'b1, bq, gq, -1, r[0], fin, rbq);
    end

    // Back-to-back: second start in the cycle after done, readback = first data.
    bq = {8'($urandom), 8'($urandom)}; gq = {0, 0};
    run_load(0, CW'($urandom_range(0, 4095)), 1'b1, bq, gq, 1, 1'b0, fin, rbq);
    init = fin;
    bq = {8'($urandom), 8'($urandom)};
    run_load(0, init, 1'b0, bq, gq, 1, 1'b0, fin, rbq);
    chk("b2b_rb_first_byte", rbq.size() > 0 ? rbq[0] : -1, init[7:0]);

    // Full-length chain with random data and occasional stalls.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) for (int i = 0; i < CW; i++) init[i] = 1'($urandom_range(0, 1));
      else init = fin;
      bq = {}; gq = {};
      for (int i = 0; i < 66; i++) begin
        bq.push_back(8'($urandom));
        gq.push_back(($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 2)));
      end
      run_load(1, init, pass == 0, bq, gq, -1, pass == 0, fin, rbq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
